fp_float2int: RTL and testbench

//  Converts a DLFloat16 operand (1 sign | 6 exp, bias 31 | 9 frac, hidden 1) to a signed INT_W integer.

---
 rtl/fp_dlf16_pkg.sv | 34 +++
 rtl/fp_f2i_round.sv | 27 ++
 rtl/fp_float2int.sv | 168 ++++++++++++++++
 tb/tb_fp_float2int.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_dlf16_pkg.sv
// DLFloat16 format constants and field helpers shared by the FPU converters.
package fp_dlf16_pkg;

    localparam int unsigned DLF_W      = 16;
    localparam int unsigned DLF_EXP_W  = 6;
    localparam int unsigned DLF_FRAC_W = 9;
    localparam int unsigned DLF_BIAS   = 31;

    // Canonical NaN: exp all ones and frac all ones; sign is ignored.
    localparam logic [DLF_W-1:0] DLF_NAN = 16'h7FFF;

    typedef enum logic {
        DLF_CLS_NUM = 1'b0,
        DLF_CLS_NAN = 1'b1
    } dlf_cls_e;

    function automatic logic dlf_sign(input logic [DLF_W-1:0] f);
        return 1'(f >> (DLF_W - 1));
    endfunction

    function automatic logic [DLF_EXP_W-1:0] dlf_exp(input logic [DLF_W-1:0] f);
        return DLF_EXP_W'(f >> DLF_FRAC_W);
    endfunction

    function automatic logic [DLF_FRAC_W-1:0] dlf_frac(input logic [DLF_W-1:0] f);
        return DLF_FRAC_W'(f);
    endfunction

    function automatic dlf_cls_e dlf_class(input logic [DLF_W-1:0] f);
        return (DLF_EXP_W'(f >> DLF_FRAC_W) == DLF_NAN[DLF_W-2:DLF_FRAC_W]) &&
               (DLF_FRAC_W'(f) == DLF_NAN[DLF_FRAC_W-1:0]) ? DLF_CLS_NAN : DLF_CLS_NUM;
    endfunction

endpackage

// File: rtl/fp_f2i_round.sv
// Rounds a right-shifted magnitude using guard/sticky; truncates or rounds to nearest-even.
module fp_f2i_round #(
    parameter int unsigned MAG_W    = 34,
    parameter bit          ROUND_NE = 1'b0
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             guard,
    input  logic             sticky,
    input  logic             sign,
    output logic [MAG_W-1:0] mag_rnd,
    output logic             inexact
);

    // Ties-to-even is symmetric in magnitude, so the sign does not change the decision.
    logic unused_sign;
    assign unused_sign = sign;

    logic inc;

    // Increment when above half, or exactly half with an odd LSB.
    always_comb begin
        inc     = ROUND_NE && guard && (sticky || mag[0]);
        mag_rnd = mag + MAG_W'(inc);
        inexact = guard || sticky;
    end

endmodule

// File: rtl/fp_float2int.sv
// DLFloat16 to signed INT_W converter, 2-stage valid/ready pipeline with saturation and flags.
module fp_float2int
    import fp_dlf16_pkg::*;
#(
    parameter int unsigned INT_W    = 32,
    parameter bit          ROUND_NE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_float,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             out_invalid,
    output logic             out_overflow,
    output logic             out_inexact
);

    // Two guard bits above INT_W absorb the rounding carry and the largest left shift.
    localparam int unsigned MW       = INT_W + 2;
    localparam int unsigned RSH_EMAX = DLF_BIAS + DLF_FRAC_W;

    localparam logic [MW-1:0]    MAG_MAX = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic [MW-1:0]    MAG_MIN = {3'b001, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic                  d_sign;
    logic [DLF_EXP_W-1:0]  d_exp;
    logic [DLF_FRAC_W-1:0] d_frac;
    dlf_cls_e              d_cls;
    logic [DLF_FRAC_W:0]   d_full;
    logic [3:0]            r_amt;
    logic [5:0]            l_amt;
    logic [19:0]           rsh;
    logic [63:0]           wide;
    logic [MW-1:0]         d_mag;
    logic                  d_guard;
    logic                  d_sticky;

    logic                  s1_valid;
    logic                  s1_nan;
    logic                  s1_sign;
    logic [MW-1:0]         s1_mag;
    logic                  s1_guard;
    logic                  s1_sticky;
    logic                  s2_load;

    logic [MW-1:0]         r_mag;
    logic                  r_inexact;

    logic [INT_W-1:0]      res_int;
    logic                  res_inv;
    logic                  res_ovf;
    logic                  res_inx;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Decode the operand into an integer magnitude plus guard/sticky bits.
    always_comb begin
        d_sign   = dlf_sign(in_float);
        d_exp    = dlf_exp(in_float);
        d_frac   = dlf_frac(in_float);
        d_cls    = dlf_class(in_float);
        d_full   = {1'b1, d_frac};
        r_amt    = 4'(RSH_EMAX - 32'(d_exp));
        l_amt    = 6'(32'(d_exp) - RSH_EMAX);
        rsh      = {d_full, 10'b0} >> r_amt;
        wide     = 64'(d_full) << l_amt;
        d_mag    = '0;
        d_guard  = 1'b0;
        d_sticky = 1'b0;
        if (d_exp == '0) begin
            d_sticky = |d_frac;
        end else if (d_exp < 6'(DLF_BIAS)) begin
            d_guard  = (d_exp == 6'(DLF_BIAS - 1));
            d_sticky = (d_exp == 6'(DLF_BIAS - 1)) ? |d_frac : 1'b1;
        end else if (d_exp <= 6'(RSH_EMAX)) begin
            d_mag    = MW'(rsh[19:10]);
            d_guard  = rsh[9];
            d_sticky = |rsh[8:0];
        end else begin
            // Clamp so narrow INT_W cannot wrap a huge value into range.
            d_mag = (|wide[63:MW]) ? '1 : wide[MW-1:0];
        end
    end

    // S1: register the classified operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_nan    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_mag    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_nan    <= (d_cls == DLF_CLS_NAN);
                s1_sign   <= d_sign;
                s1_mag    <= d_mag;
                s1_guard  <= d_guard;
                s1_sticky <= d_sticky;
            end
        end
    end

    fp_f2i_round #(
        .MAG_W    (MW),
        .ROUND_NE (ROUND_NE)
    ) u_round (
        .mag     (s1_mag),
        .guard   (s1_guard),
        .sticky  (s1_sticky),
        .sign    (s1_sign),
        .mag_rnd (r_mag),
        .inexact (r_inexact)
    );

    // Saturate the rounded magnitude and apply the sign.
    always_comb begin
        res_int = '0;
        res_inv = 1'b0;
        res_ovf = 1'b0;
        res_inx = r_inexact;
        if (s1_nan) begin
            res_int = INT_MIN;
            res_inv = 1'b1;
            res_inx = 1'b0;
        end else if (!s1_sign && (r_mag > MAG_MAX)) begin
            res_int = INT_MAX;
            res_ovf = 1'b1;
            res_inx = 1'b0;
        end else if (s1_sign && (r_mag > MAG_MIN)) begin
            res_int = INT_MIN;
            res_ovf = 1'b1;
            res_inx = 1'b0;
        end else if (s1_sign) begin
            res_int = -r_mag[INT_W-1:0];
        end else begin
            res_int = r_mag[INT_W-1:0];
        end
    end

    // S2: register the final result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_int      <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_int      <= res_int;
                out_invalid  <= res_inv;
                out_overflow <= res_ovf;
                out_inexact  <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_float2int.sv
// Bench for fp_float2int: truncating and round-to-nearest-even instances driven in lockstep.
module tb_fp_float2int;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_float  = 16'h0;

    logic        rdy_tr, ov_tr, inv_tr, ovf_tr, inx_tr;
    logic        rdy_ne, ov_ne, inv_ne, ovf_ne, inx_ne;
    logic [31:0] oi_tr, oi_ne;

    always #5 clk = ~clk;

    fp_float2int #(.INT_W(32), .ROUND_NE(1'b0)) dut_tr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_tr), .in_float(in_float),
        .out_valid(ov_tr), .out_ready(out_ready), .out_int(oi_tr),
        .out_invalid(inv_tr), .out_overflow(ovf_tr), .out_inexact(inx_tr)
    );

    fp_float2int #(.INT_W(32), .ROUND_NE(1'b1)) dut_ne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_ne), .in_float(in_float),
        .out_valid(ov_ne), .out_ready(out_ready), .out_int(oi_ne),
        .out_invalid(inv_ne), .out_overflow(ovf_ne), .out_inexact(inx_ne)
    );

    int errors = 0;
    int checks = 0;

    // Expected entries are {int[31:0], invalid, overflow, inexact}.
    logic [34:0] q_tr[$];
    logic [34:0] q_ne[$];
    logic [34:0] nxt_tr = '0;
    logic [34:0] nxt_ne = '0;
    int          n_out_tr = 0;
    int          n_out_ne = 0;
    bit          saw_block = 1'b0;
    bit          stall_tr = 1'b0;
    bit          stall_ne = 1'b0;
    logic [35:0] hold_tr = '0;
    logic [35:0] hold_ne = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [34:0] ex(input logic [31:0] v, input logic [2:0] fl);
        return {v, fl};
    endfunction

    // Reference: value = {1,frac} * 2^(exp-40); work in fixed point scaled by 2^40.
    function automatic logic [34:0] model(input logic [15:0] f, input bit ne);
        logic [127:0] q;
        logic [127:0] ip;
        logic [127:0] lim;
        logic [39:0]  rem;
        logic [31:0]  r;
        if (f[14:9] == 6'h3F && f[8:0] == 9'h1FF) return {32'h8000_0000, 3'b100};
        if (f[14:9] == 6'h00) return {32'h0, 2'b00, (f[8:0] != 9'h0)};
        q   = 128'({1'b1, f[8:0]}) << f[14:9];
        ip  = q >> 40;
        rem = q[39:0];
        if (ne && ((rem > 40'h80_0000_0000) || (rem == 40'h80_0000_0000 && ip[0])))
            ip = ip + 128'd1;
        lim = f[15] ? 128'h8000_0000 : 128'h7FFF_FFFF;
        if (ip > lim) return {(f[15] ? 32'h8000_0000 : 32'h7FFF_FFFF), 3'b010};
        r = ip[31:0];
        if (f[15]) r = -r;
        return {r, 2'b00, (rem != 40'h0)};
    endfunction

    // Monitor: push on input transfer, pop and compare on output transfer, check stall holding.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_tr = 1'b0;
                stall_ne = 1'b0;
            end else begin
                if (in_valid && rdy_tr) begin
                    q_tr.push_back(nxt_tr);
                    q_ne.push_back(nxt_ne);
                end
                if (in_valid && !rdy_tr) saw_block = 1'b1;
                if (stall_tr) chk("stall_hold_tr", 64'({ov_tr, oi_tr, inv_tr, ovf_tr, inx_tr}), 64'(hold_tr));
                if (stall_ne) chk("stall_hold_ne", 64'({ov_ne, oi_ne, inv_ne, ovf_ne, inx_ne}), 64'(hold_ne));
                if (ov_tr && out_ready) begin
                    n_out_tr++;
                    if (q_tr.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL sb_underflow_tr: observed=output expected=none");
                    end else begin
                        e = q_tr.pop_front();
                        chk("result_tr", 64'({oi_tr, inv_tr, ovf_tr, inx_tr}), 64'(e));
                    end
                end
                if (ov_ne && out_ready) begin
                    n_out_ne++;
                    if (q_ne.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL sb_underflow_ne: observed=output expected=none");
                    end else begin
                        e = q_ne.pop_front();
                        chk("result_ne", 64'({oi_ne, inv_ne, ovf_ne, inx_ne}), 64'(e));
                    end
                end
                stall_tr = ov_tr && !out_ready;
                stall_ne = ov_ne && !out_ready;
                hold_tr  = {ov_tr, oi_tr, inv_tr, ovf_tr, inx_tr};
                hold_ne  = {ov_ne, oi_ne, inv_ne, ovf_ne, inx_ne};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Present one operand from the posedge+1 phase; returns one step after its transfer edge.
    task automatic send(input logic [15:0] f, input logic [34:0] etr, input logic [34:0] ene);
        int n;
        bit acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_float = f;
        nxt_tr   = etr;
        nxt_ne   = ene;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy_tr;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic lat(input logic [15:0] f, input logic [34:0] etr, input logic [34:0] ene);
        send(f, etr, ene);
        @(negedge clk);
        chk("lat_cycle1_tr", 64'(ov_tr), 64'd0);
        chk("lat_cycle1_ne", 64'(ov_ne), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_cycle2_tr", 64'(ov_tr), 64'd1);
        chk("lat_cycle2_ne", 64'(ov_ne), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_tr.size() != 0 || q_ne.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_tr", 64'(q_tr.size()), 64'd0);
        chk("drain_ne", 64'(q_ne.size()), 64'd0);
    endtask

    initial begin
        int          base_tr;
        int          base_ne;
        logic [15:0] f;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid_tr", 64'(ov_tr), 64'd0);
        chk("rst_valid_ne", 64'(ov_ne), 64'd0);
        chk("rst_data_tr", 64'({oi_tr, inv_tr, ovf_tr, inx_tr}), 64'd0);
        chk("rst_data_ne", 64'({oi_ne, inv_ne, ovf_ne, inx_ne}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic conversion with latency
        lat(16'h3E00, ex(32'h1, 3'b000), ex(32'h1, 3'b000));

        // Directed values, streamed back-to-back
        send(16'hC280, ex(32'hFFFF_FFFB, 3'b000), ex(32'hFFFF_FFFB, 3'b000));
        send(16'h4080, ex(32'h2, 3'b001), ex(32'h2, 3'b001));
        send(16'h4180, ex(32'h3, 3'b001), ex(32'h4, 3'b001));
        send(16'hC180, ex(32'hFFFF_FFFD, 3'b001), ex(32'hFFFF_FFFC, 3'b001));
        send(16'h3C00, ex(32'h0, 3'b001), ex(32'h0, 3'b001));
        send(16'h3D00, ex(32'h0, 3'b001), ex(32'h1, 3'b001));
        send(16'hBD00, ex(32'h0, 3'b001), ex(32'hFFFF_FFFF, 3'b001));
        send(16'h4100, ex(32'h3, 3'b000), ex(32'h3, 3'b000));
        send(16'h7C00, ex(32'h7FFF_FFFF, 3'b010), ex(32'h7FFF_FFFF, 3'b010));
        send(16'hFC00, ex(32'h8000_0000, 3'b000), ex(32'h8000_0000, 3'b000));
        send(16'hFE00, ex(32'h8000_0000, 3'b010), ex(32'h8000_0000, 3'b010));
        send(16'h7FFF, ex(32'h8000_0000, 3'b100), ex(32'h8000_0000, 3'b100));
        send(16'hFFFF, ex(32'h8000_0000, 3'b100), ex(32'h8000_0000, 3'b100));
        send(16'h0000, ex(32'h0, 3'b000), ex(32'h0, 3'b000));
        send(16'h8000, ex(32'h0, 3'b000), ex(32'h0, 3'b000));
        send(16'h0001, ex(32'h0, 3'b001), ex(32'h0, 3'b001));
        drain();

        // Random operands against the reference model
        repeat (40) begin
            f = 16'($urandom);
            send(f, model(f, 1'b0), model(f, 1'b1));
        end
        drain();

        // Backpressure: 6 operands, consumer stalls 5 cycles mid-stream
        base_tr   = n_out_tr;
        base_ne   = n_out_ne;
        saw_block = 1'b0;
        send(16'h3E00, ex(32'h1, 3'b000), ex(32'h1, 3'b000));
        send(16'h4000, ex(32'h2, 3'b000), ex(32'h2, 3'b000));
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(16'h4100, ex(32'h3, 3'b000), ex(32'h3, 3'b000));
        send(16'h4200, ex(32'h4, 3'b000), ex(32'h4, 3'b000));
        send(16'h4280, ex(32'h5, 3'b000), ex(32'h5, 3'b000));
        send(16'h4300, ex(32'h6, 3'b000), ex(32'h6, 3'b000));
        drain();
        chk("bp_in_ready_drop", 64'(saw_block), 64'd1);
        chk("bp_count_tr", 64'(n_out_tr - base_tr), 64'd6);
        chk("bp_count_ne", 64'(n_out_ne - base_ne), 64'd6);

        // Asynchronous reset with two operands in flight
        send(16'h4200, ex(32'h4, 3'b000), ex(32'h4, 3'b000));
        send(16'h4300, ex(32'h6, 3'b000), ex(32'h6, 3'b000));
        #1;
        chk("pre_reset_valid_tr", 64'(ov_tr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid_tr", 64'(ov_tr), 64'd0);
        chk("async_reset_valid_ne", 64'(ov_ne), 64'd0);
        chk("async_reset_data_tr", 64'({oi_tr, inv_tr, ovf_tr, inx_tr}), 64'd0);
        q_tr.delete();
        q_ne.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_empty_tr", 64'(ov_tr), 64'd0);
        chk("post_reset_empty_ne", 64'(ov_ne), 64'd0);
        @(posedge clk);
        #1;
        lat(16'hC280, ex(32'hFFFF_FFFB, 3'b000), ex(32'hFFFF_FFFB, 3'b000));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
